cpu_mem_ctrl: RTL and testbench



---
 rtl/cpu_mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_cpu_mem_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_ctrl.sv
// CPU memory/IO controller: block RAM, LED/button registers and unmapped wait states.
// Define CPU_MEM_TIMER_EN to add the free-running 16-bit timer at IO_BASE+2/+3.
module cpu_mem_ctrl #(
    parameter int          RAM_AW   = 12,
    parameter logic [15:0] IO_BASE  = 16'hFF00,
    parameter int          EXT_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_done,
    input  logic [3:0]  buttons,
    output logic [7:0]  leds
);
    typedef enum logic [1:0] {IDLE, RAMRD, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  leds_q, leds_d;
    logic        wr_q, wr_d;
    logic [3:0]  btn_s1_q, btn_s2_q;
    logic [7:0]  ram_q;
    logic        ram_we;
    logic [7:0]  mem [0:(1<<RAM_AW)-1];

    logic req, is_ram, is_led, is_btn;
    assign req    = cpu_read | cpu_write;
    assign is_ram = (cpu_addr >> RAM_AW) == 16'd0;
    assign is_led = cpu_addr == IO_BASE;
    assign is_btn = cpu_addr == IO_BASE + 16'd1;

`ifdef CPU_MEM_TIMER_EN
    logic [15:0] timer_q;
    logic [7:0]  snap_q;
    logic        tmr_clr, snap_ld, is_tmr_lo, is_tmr_hi;
    assign is_tmr_lo = cpu_addr == IO_BASE + 16'd2;
    assign is_tmr_hi = cpu_addr == IO_BASE + 16'd3;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= 16'd0;
            snap_q  <= 8'd0;
        end else begin
            timer_q <= tmr_clr ? 16'd0 : timer_q + 16'd1;
            if (snap_ld) snap_q <= timer_q[15:8];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        leds_d  = leds_q;
        wr_d    = wr_q;
        ram_we  = 1'b0;
`ifdef CPU_MEM_TIMER_EN
        tmr_clr = 1'b0;
        snap_ld = 1'b0;
`endif
        case (state_q)
            IDLE: if (req) begin
                // Simultaneous read and write resolves to a write.
                wr_d = cpu_write;
                if (is_ram) begin
                    ram_we  = cpu_write;
                    state_d = cpu_write ? DONE : RAMRD;
                end else if (is_led) begin
                    if (cpu_write) leds_d = cpu_wdata;
                    else           rdata_d = leds_q;
                    state_d = DONE;
                end else if (is_btn) begin
                    if (!cpu_write) rdata_d = {4'b0, btn_s2_q};
                    state_d = DONE;
                end
`ifdef CPU_MEM_TIMER_EN
                else if (is_tmr_lo || is_tmr_hi) begin
                    if (cpu_write) begin
                        tmr_clr = 1'b1;
                    end else if (is_tmr_lo) begin
                        rdata_d = timer_q[7:0];
                        snap_ld = 1'b1;
                    end else begin
                        rdata_d = snap_q;
                    end
                    state_d = DONE;
                end
`endif
                else if (EXT_WAIT == 0) begin
                    if (!cpu_write) rdata_d = 8'hFF;
                    state_d = DONE;
                end else begin
                    cnt_d   = 4'(EXT_WAIT);
                    state_d = WAIT;
                end
            end
            RAMRD: begin
                rdata_d = ram_q;
                state_d = DONE;
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    if (!wr_q) rdata_d = 8'hFF;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rdata_q  <= 8'd0;
            leds_q   <= 8'd0;
            wr_q     <= 1'b0;
            btn_s1_q <= 4'd0;
            btn_s2_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            leds_q   <= leds_d;
            wr_q     <= wr_d;
            btn_s1_q <= buttons;
            btn_s2_q <= btn_s1_q;
        end
    end

    // Block RAM: contents survive reset, read data lags the address by one edge.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) mem[cpu_addr[RAM_AW-1:0]] <= cpu_wdata;
        ram_q <= mem[cpu_addr[RAM_AW-1:0]];
    end

    assign cpu_rdata = rdata_q;
    assign cpu_done  = state_q == DONE;
    assign leds      = leds_q;
endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Directed bench for cpu_mem_ctrl: transaction-level model plus per-cycle output compare.
module tb_cpu_mem_ctrl;
    localparam int W = 3;

    logic        clk = 1'b0, reset = 1'b1;
    logic [15:0] cpu_addr = 16'd0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic [3:0]  buttons = 4'h9;
    logic [7:0]  cpu_rdata, leds;
    logic        cpu_done;

    logic [15:0] r0_addr = 16'd0;
    logic        r0_read = 1'b0;
    logic [7:0]  d0_rdata, d0_leds;
    logic        d0_done;

    cpu_mem_ctrl #(.RAM_AW(12), .IO_BASE(16'hFF00), .EXT_WAIT(W)) u_dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .buttons(buttons), .leds(leds));

    cpu_mem_ctrl #(.RAM_AW(12), .IO_BASE(16'hFF00), .EXT_WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .cpu_addr(r0_addr), .cpu_wdata(8'h00),
        .cpu_read(r0_read), .cpu_write(1'b0), .cpu_rdata(d0_rdata),
        .cpu_done(d0_done), .buttons(buttons), .leds(d0_leds));

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_s = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= reset;
    end

    int          nvec = 0, nfail = 0;
    logic [7:0]  mem_m [4096];
    logic [7:0]  led_m = 8'd0, hold_rd = 8'd0, exp_rd = 8'd0, snap_m = 8'd0;
    bit          exp_rd_v = 1'b0, chk_en = 1'b0;
    int          exp_done = -1, n_samp = 0, tclr = 0, lat;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Outputs every cycle: done only on the predicted cycle, rdata held between reads.
    task automatic cmp_cycle();
        if (rst_s) hold_rd = 8'd0;
        if (cyc == exp_done) begin
            chk("done_hi", 16'(cpu_done), 16'h1);
            if (exp_rd_v) hold_rd = exp_rd;
            chk("rdata_done", 16'(cpu_rdata), 16'(hold_rd));
        end else begin
            chk("done_lo", 16'(cpu_done), 16'h0);
            chk("rdata_hold", 16'(cpu_rdata), 16'(hold_rd));
        end
        chk("leds", 16'(leds), 16'(led_m));
    endtask

    task automatic launch(input logic [15:0] a, input logic [7:0] d, input bit rd, input bit wr);
        int          l;
        logic [7:0]  r;
        logic [15:0] t;
        @(negedge clk);
        cpu_addr = a; cpu_wdata = d; cpu_read = rd; cpu_write = wr;
        n_samp = cyc + 1;
        r = 8'hFF;
        l = 1 + W;
        if (a[15:12] == 4'h0) begin
            l = wr ? 1 : 2;
            if (wr) mem_m[a[11:0]] = d;
            else    r = mem_m[a[11:0]];
        end else if (a == 16'hFF00) begin
            l = 1; r = led_m;
        end else if (a == 16'hFF01) begin
            l = 1; r = {4'h0, buttons};
        end
`ifdef CPU_MEM_TIMER_EN
        else if (a == 16'hFF02 || a == 16'hFF03) begin
            l = 1;
            t = 16'(n_samp - 1 - tclr);
            if (wr) tclr = n_samp;
            else if (a == 16'hFF02) begin r = t[7:0]; snap_m = t[15:8]; end
            else r = snap_m;
        end
`endif
        exp_rd = r; exp_rd_v = !wr;
        exp_done = n_samp + l - 1;
        @(posedge clk);
        if (wr && a == 16'hFF00) led_m = d;
    endtask

    task automatic finish(output int l);
        bit seen = 1'b0;
        l = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (cpu_done) begin seen = 1'b1; l = cyc - n_samp + 1; end
        end
        if (!seen) begin
            nvec++; nfail++;
            $display("FAIL timeout: no done within 40 cycles of sampling at %0d", n_samp);
        end
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (chk_en) cmp_cycle();
            end
        join_none
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; chk_en = 1'b1;
        chk("rst_done", 16'(cpu_done), 16'h0);
        chk("rst_rdata", 16'(cpu_rdata), 16'h0);
        chk("rst_leds", 16'(leds), 16'h0);

        launch(16'h0123, 8'h5A, 0, 1); finish(lat); chk("ramwr_lat", 16'(lat), 16'h1);
        launch(16'h0123, 8'h00, 1, 0); finish(lat); chk("ramrd_lat", 16'(lat), 16'h2);
        chk("ramrd_data", 16'(cpu_rdata), 16'h5A);
        repeat (3) @(negedge clk);
        chk("ramrd_held", 16'(cpu_rdata), 16'h5A);

        launch(16'hFF00, 8'hA5, 0, 1); finish(lat); chk("ledwr_lat", 16'(lat), 16'h1);
        chk("leds_a5", 16'(leds), 16'hA5);
        launch(16'hFF00, 8'h00, 1, 0); finish(lat); chk("ledrd_lat", 16'(lat), 16'h1);
        chk("ledrd_data", 16'(cpu_rdata), 16'hA5);
        launch(16'hFF01, 8'h00, 1, 0); finish(lat); chk("btn_data", 16'(cpu_rdata), 16'h09);
        launch(16'hFF01, 8'h33, 0, 1); finish(lat); chk("btn_wr_ign", 16'(cpu_rdata), 16'h09);

        launch(16'h8000, 8'h00, 1, 0); finish(lat); chk("unm_rd_lat", 16'(lat), 16'h4);
        chk("unm_rd_data", 16'(cpu_rdata), 16'hFF);
        launch(16'h8000, 8'h77, 0, 1); finish(lat); chk("unm_wr_lat", 16'(lat), 16'h4);

        launch(16'h0010, 8'h3C, 1, 1); finish(lat); chk("rw_lat", 16'(lat), 16'h1);
        chk("rw_rdata_kept", 16'(cpu_rdata), 16'hFF);
        launch(16'h0010, 8'h00, 1, 0); finish(lat); chk("rw_readback", 16'(cpu_rdata), 16'h3C);

        launch(16'h0FFF, 8'hE1, 0, 1); finish(lat);
        launch(16'h0FFF, 8'h00, 1, 0); finish(lat); chk("ram_top", 16'(cpu_rdata), 16'hE1);
        launch(16'h1000, 8'h00, 1, 0); finish(lat); chk("ram_edge_lat", 16'(lat), 16'h4);
        launch(16'hFF04, 8'h00, 1, 0); finish(lat); chk("io_unm_lat", 16'(lat), 16'h4);
`ifndef CPU_MEM_TIMER_EN
        launch(16'hFF02, 8'h00, 1, 0); finish(lat); chk("tmr_off_lat", 16'(lat), 16'h4);
        chk("tmr_off_data", 16'(cpu_rdata), 16'hFF);
`endif

        @(negedge clk);
        r0_addr = 16'h8000; r0_read = 1'b1;
        @(negedge clk);
        chk("ew0_done", 16'(d0_done), 16'h1);
        chk("ew0_data", 16'(d0_rdata), 16'hFF);
        r0_read = 1'b0;
        @(negedge clk);
        chk("ew0_done_lo", 16'(d0_done), 16'h0);

        launch(16'h8000, 8'h00, 1, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; cpu_read = 1'b0; exp_done = -1;
        @(posedge clk);
        led_m = 8'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_leds", 16'(leds), 16'h0);
        chk("rst_mid_rdata", 16'(cpu_rdata), 16'h0);
        repeat (4) @(negedge clk);
        launch(16'hFF00, 8'h00, 1, 0); finish(lat); chk("post_rst_lat", 16'(lat), 16'h1);
        chk("post_rst_data", 16'(cpu_rdata), 16'h00);

`ifdef CPU_MEM_TIMER_EN
        launch(16'hFF02, 8'h00, 0, 1); finish(lat); chk("tmr_clr_lat", 16'(lat), 16'h1);
        launch(16'hFF02, 8'h00, 1, 0); finish(lat); chk("tmr_lo_1", 16'(cpu_rdata), 16'h01);
        launch(16'hFF02, 8'h00, 0, 1); finish(lat);
        repeat (254) @(negedge clk);
        launch(16'hFF02, 8'h00, 1, 0); finish(lat); chk("tmr_lo_ff", 16'(cpu_rdata), 16'hFF);
        launch(16'hFF03, 8'h00, 1, 0); finish(lat); chk("tmr_hi_snap", 16'(cpu_rdata), 16'h00);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
